// File: rtl/seg7_mux_display.sv
// Multiplexed 7-segment driver: serial double-dabble binary-to-BCD conversion,
// one-hot digit scan, leading-zero blanking, overflow dashes and optional inversion.
module seg7_mux_display #(
    parameter int DIGITS      = 2,
    parameter int BIN_W       = 7,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Accumulator must hold every decimal digit of a BIN_W-bit value, and at least DIGITS.
    localparam int NBCD0 = (BIN_W * 3) / 10 + 1;
    localparam int NBCD  = (NBCD0 > DIGITS) ? NBCD0 : DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int BC_W  = $clog2(BIN_W + 1);
    localparam logic [31:0] MAXV = 32'(pow10(DIGITS) - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [0:0]                state_q, state_d;
    logic [BIN_W-1:0]          bin_q, bin_d, bin_sh;
    logic [NBCD-1:0][3:0]      bcd_q, bcd_d, bcd_adj, bcd_sh;
    logic [BC_W-1:0]           bitcnt_q, bitcnt_d;
    logic [DIGITS-1:0][3:0]    dig_q, dig_d;
    logic                      ovf_q, ovf_d, ovf_nxt_q, ovf_nxt_d;
    logic [CNT_W-1:0]          refcnt_q, refcnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [6:0]                seg_q, seg_d;
    logic [DIGITS-1:0]         an_q, an_d;
    logic [DIGITS-1:0]         upper_zero;

    // One double-dabble step: correct nibbles >=5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NBCD; i++)
            if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
        {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bitcnt_d  = bitcnt_q;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        ovf_nxt_d = ovf_nxt_q;
        case (state_q)
            S_IDLE: if (load) begin
                state_d   = S_CONV;
                bin_d     = value;
                bcd_d     = '0;
                bitcnt_d  = '0;
                ovf_nxt_d = 32'(value) > MAXV;
            end
            default: begin
                bin_d    = bin_sh;
                bcd_d    = bcd_sh;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BC_W'(BIN_W - 1)) begin
                    state_d = S_IDLE;
                    dig_d   = bcd_sh[DIGITS-1:0];
                    ovf_d   = ovf_nxt_q;
                end
            end
        endcase
    end

    // upper_zero[k]: digits k..DIGITS-1 are all zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc           = acc & (dig_q[k] == 4'd0);
            upper_zero[k] = acc;
        end
    end

    always_comb begin
        refcnt_d = refcnt_q + 1'b1;
        idx_d    = idx_q;
        if (refcnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            refcnt_d = '0;
            idx_d    = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d = DIGITS'(1) << idx_q;
        if (ovf_q)
            seg_d = 7'h40;
        else if (blank_lz && idx_q != '0 && upper_zero[idx_q])
            seg_d = 7'h00;
        else
            seg_d = pattern(dig_q[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            bitcnt_q  <= '0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_nxt_q <= 1'b0;
            refcnt_q  <= '0;
            idx_q     <= '0;
            seg_q     <= '0;
            an_q      <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bitcnt_q  <= bitcnt_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            ovf_nxt_q <= ovf_nxt_d;
            refcnt_q  <= refcnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign busy     = (state_q == S_CONV);
    assign overflow = ovf_q;
    assign seg      = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an       = (ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Randomised bench for seg7_mux_display: two configurations driven in lockstep and
// compared every cycle against a decimal-arithmetic model of the readout.
module tb_seg7_mux_display;

    localparam int BW = 7;
    localparam int D0 = 2, R0 = 4;
    localparam int D1 = 3, R1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [BW-1:0] value = '0;
    logic load = 1'b0;
    logic blank_lz = 1'b0;

    logic busy_a, ovf_a, busy_b, ovf_b;
    logic [6:0] seg_a, seg_b;
    logic [D0-1:0] an_a;
    logic [D1-1:0] an_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_mux_display #(.DIGITS(D0), .BIN_W(BW), .REFRESH_DIV(R0), .ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

    seg7_mux_display #(.DIGITS(D1), .BIN_W(BW), .REFRESH_DIV(R1), .ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

    function automatic int pw10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic int ref_seg(input int v, input bit o, input int k, input bit blz);
        int p = pw10(k);
        if (o) return 'h40;
        if (blz && k > 0 && v < p) return 0;
        case ((v / p) % 10)
            0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
            4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
            8: return 'h7F;  default: return 'h6F;
        endcase
    endfunction

    // Model state per instance: cycles left in conversion, pending and shown value,
    // edges since reset (scan position follows from it arithmetically).
    int  dd[2] = '{D0, D1};
    int  rr[2] = '{R0, R1};
    int  m_rem[2], m_pend[2], m_disp[2], m_n[2];
    bit  m_ovf[2];
    int  e_seg[2], e_an[2];

    initial for (int u = 0; u < 2; u++) begin
        m_rem[u] = 0; m_pend[u] = 0; m_disp[u] = 0; m_n[u] = 0;
        m_ovf[u] = 0; e_seg[u] = 0; e_an[u] = 0;
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_rem[u] = 0; m_disp[u] = 0; m_ovf[u] = 0; m_n[u] = 0;
                e_seg[u] = 0; e_an[u] = 0;
            end else begin
                int k;
                k = (m_n[u] / rr[u]) % dd[u];
                e_seg[u] = ref_seg(m_disp[u], m_ovf[u], k, blank_lz);
                e_an[u]  = 1 << k;
                m_n[u]++;
                if (m_rem[u] > 0) begin
                    m_rem[u]--;
                    if (m_rem[u] == 0) begin
                        m_disp[u] = m_pend[u];
                        m_ovf[u]  = m_pend[u] > pw10(dd[u]) - 1;
                    end
                end else if (load) begin
                    m_pend[u] = int'(value);
                    m_rem[u]  = BW;
                end
            end
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("seg_a",  int'(seg_a),  e_seg[0]);
        chk("an_a",   int'(an_a),   e_an[0]);
        chk("busy_a", int'(busy_a), int'(m_rem[0] > 0));
        chk("ovf_a",  int'(ovf_a),  int'(m_ovf[0]));
        chk("seg_b",  int'(seg_b),  e_seg[1] ^ 'h7F);
        chk("an_b",   int'(an_b),   e_an[1] ^ 'h7);
        chk("busy_b", int'(busy_b), int'(m_rem[1] > 0));
        chk("ovf_b",  int'(ovf_b),  int'(m_ovf[1]));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_val(input int v);
        value = BW'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        load_val(15);  cycles(30);
        blank_lz = 1'b1;
        load_val(6);   cycles(20);
        blank_lz = 1'b0; cycles(10);
        load_val(100); cycles(20);
        load_val(20);  cycles(20);

        // Load during busy is dropped, including on the edge busy falls.
        load_val(20);  cycles(2);
        load_val(99);  cycles(12);
        load_val(99);  cycles(20);
        load_val(50);  cycles(6);
        load_val(33);  cycles(12);

        // Reset in the middle of a conversion.
        load_val(88);  cycles(3);
        rst_n = 1'b0;  step();
        rst_n = 1'b1;  cycles(10);

        blank_lz = 1'b1;
        load_val(7);   cycles(20);

        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 5) == 0);
            value = BW'($urandom_range(0, 127));
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            rst_n = ($urandom_range(0, 400) != 0);
            step();
        end
        load = 1'b0;
        rst_n = 1'b1;
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
